// File: rtl/kvs_pkg.sv
// -----------------------------------------------------------------------------
// kvs_pkg
// Shared definitions for the KVS request client:
//   - flag op-codes used on the request and response paths
//   - client FSM state encoding
//   - clog2 helper for parameter-derived widths
// -----------------------------------------------------------------------------
package kvs_pkg;

  // Request op-codes (req_flag / in_flag)
  localparam logic [3:0] FLAG_GET  = 4'h1;
  localparam logic [3:0] FLAG_SET  = 4'h2;
  localparam logic [3:0] FLAG_DEL  = 4'h3;
  // Response codes (out_flag / rsp_flag); a synthesised timeout answer uses 0
  localparam logic [3:0] FLAG_HIT  = 4'h8;
  localparam logic [3:0] FLAG_MISS = 4'h9;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FLUSH = 2'd1,
    ST_QUIET = 2'd2
  } kvs_state_e;

  // Ceiling log2; clog2(1) = 0
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/kvs_tag_fifo.sv
// -----------------------------------------------------------------------------
// kvs_tag_fifo
// Synchronous show-ahead FIFO holding the tags of outstanding requests.
// DEPTH must be a power of two (pointers wrap naturally).
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   push, din  : write din at the tail
//   pop        : drop the head entry
//   dout       : current head (valid whenever count != 0)
//   count      : number of stored entries, 0..DEPTH
// The caller guarantees no push when full and no pop when empty.
// -----------------------------------------------------------------------------
module kvs_tag_fifo import kvs_pkg::*; #(
  parameter int  DEPTH = 8,
  parameter int  WIDTH = 3,
  localparam int PTR_W = clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= din;
  end

  assign dout  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/kvs_req_client.sv
// -----------------------------------------------------------------------------
// kvs_req_client
// Network-side initiator of the KVS lookup interface. Issues parser requests
// to the DB, pairs in-order DB responses with their tags, and flushes all
// outstanding requests with timeout responses if the DB stops answering.
// Ports:
//   clk, rst_n                  : DB-domain clock, asynchronous active-low reset
//   req_key/req_flag/req_valid  : request from the parser
//   req_ready, req_tag          : accept indication and tag the request will get
//   in_key/in_flag/in_valid     : registered request pulse to the DB
//   out_valid/out_flag          : in-order DB response pulse
//   rsp_valid/rsp_flag/rsp_tag  : registered tagged response pulse downstream
//   rsp_timeout                 : response was synthesised by the flush
//   err_unexp                   : DB response with nothing outstanding
//   dbg_state                   : current FSM state (observation only)
//
// Handshake: a request transfers in any cycle where req_valid && req_ready;
// req_ready is combinational from state and occupancy only, never from
// req_valid. in_valid, out_valid and rsp_valid are single-cycle pulses with
// no backpressure: the receiver must take them in the cycle they are high.
// -----------------------------------------------------------------------------
module kvs_req_client import kvs_pkg::*; #(
  parameter int  KEY_SIZE = 96,
  parameter int  FLAG_W   = 4,
  parameter int  MAX_OUT  = 8,
  parameter int  TIMEOUT  = 255,
  localparam int TAG_W    = clog2(MAX_OUT)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [KEY_SIZE-1:0] req_key,
  input  logic [FLAG_W-1:0]   req_flag,
  input  logic                req_valid,
  output logic                req_ready,
  output logic [TAG_W-1:0]    req_tag,
  output logic [KEY_SIZE-1:0] in_key,
  output logic [FLAG_W-1:0]   in_flag,
  output logic                in_valid,
  input  logic                out_valid,
  input  logic [FLAG_W-1:0]   out_flag,
  output logic                rsp_valid,
  output logic [FLAG_W-1:0]   rsp_flag,
  output logic [TAG_W-1:0]    rsp_tag,
  output logic                rsp_timeout,
  output logic                err_unexp,
  output kvs_state_e          dbg_state
);

  localparam int CNT_W = TAG_W + 1;
  localparam int AGE_W = clog2(TIMEOUT + 1);

  kvs_state_e          state_q, state_d;
  logic [TAG_W-1:0]    issue_tag_q, issue_tag_d;
  logic [AGE_W-1:0]    age_q, age_d;
  logic [AGE_W-1:0]    quiet_q, quiet_d;
  logic [KEY_SIZE-1:0] in_key_q, in_key_d;
  logic [FLAG_W-1:0]   in_flag_q, in_flag_d;
  logic                in_valid_q, in_valid_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [FLAG_W-1:0]   rsp_flag_q, rsp_flag_d;
  logic [TAG_W-1:0]    rsp_tag_q, rsp_tag_d;
  logic                rsp_timeout_q, rsp_timeout_d;
  logic                err_unexp_q, err_unexp_d;

  logic                accept;
  logic                pop_run;
  logic                pop_flush;
  logic                pop;
  logic [TAG_W-1:0]    head_tag;
  logic [CNT_W-1:0]    count;

  assign req_ready = (state_q == ST_RUN) && (count < CNT_W'(MAX_OUT));
  assign req_tag   = issue_tag_q;
  assign accept    = req_valid && req_ready;

  // A DB response only pops in RUN with something outstanding; the tag being
  // pushed this cycle is never visible at the head, so same-cycle push/pop
  // always answers an older request.
  assign pop_run   = (state_q == ST_RUN) && out_valid && (count != '0);
  assign pop_flush = (state_q == ST_FLUSH) && (count != '0);
  assign pop       = pop_run || pop_flush;

  kvs_tag_fifo #(
    .DEPTH (MAX_OUT),
    .WIDTH (TAG_W)
  ) u_tag_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (accept),
    .pop   (pop),
    .din   (issue_tag_q),
    .dout  (head_tag),
    .count (count)
  );

  // FSM and counters
  always_comb begin
    state_d     = state_q;
    quiet_d     = '0;
    issue_tag_d = issue_tag_q;
    age_d       = '0;

    if (accept) issue_tag_d = issue_tag_q + TAG_W'(1);

    // age tracks how long the head request has waited; it restarts on every
    // answer and is idle whenever nothing is outstanding or outside RUN.
    if (state_q == ST_RUN && !pop && count != '0 && age_q != AGE_W'(TIMEOUT)) begin
      age_d = age_q + AGE_W'(1);
    end

    case (state_q)
      ST_RUN: begin
        if (age_q == AGE_W'(TIMEOUT)) state_d = ST_FLUSH;
      end
      ST_FLUSH: begin
        // Nothing is pushed in FLUSH, so the entry popped with count==1 is last.
        if (count <= CNT_W'(1)) state_d = ST_QUIET;
      end
      ST_QUIET: begin
        // Hold off new traffic for TIMEOUT cycles so late DB answers to the
        // flushed requests are absorbed instead of being matched to new tags.
        if (quiet_q == AGE_W'(TIMEOUT - 1)) begin
          state_d = ST_RUN;
        end else begin
          quiet_d = quiet_q + AGE_W'(1);
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  // Issue and response registers
  always_comb begin
    in_key_d      = in_key_q;
    in_flag_d     = in_flag_q;
    in_valid_d    = accept;
    rsp_valid_d   = pop;
    rsp_flag_d    = '0;
    rsp_tag_d     = '0;
    rsp_timeout_d = 1'b0;
    err_unexp_d   = (state_q == ST_RUN) && out_valid && (count == '0);

    if (accept) begin
      in_key_d  = req_key;
      in_flag_d = req_flag;
    end
    if (pop) begin
      rsp_tag_d     = head_tag;
      rsp_flag_d    = pop_run ? out_flag : '0;
      rsp_timeout_d = pop_flush;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_RUN;
      issue_tag_q   <= '0;
      age_q         <= '0;
      quiet_q       <= '0;
      in_key_q      <= '0;
      in_flag_q     <= '0;
      in_valid_q    <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_flag_q    <= '0;
      rsp_tag_q     <= '0;
      rsp_timeout_q <= 1'b0;
      err_unexp_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      issue_tag_q   <= issue_tag_d;
      age_q         <= age_d;
      quiet_q       <= quiet_d;
      in_key_q      <= in_key_d;
      in_flag_q     <= in_flag_d;
      in_valid_q    <= in_valid_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_flag_q    <= rsp_flag_d;
      rsp_tag_q     <= rsp_tag_d;
      rsp_timeout_q <= rsp_timeout_d;
      err_unexp_q   <= err_unexp_d;
    end
  end

  assign in_key      = in_key_q;
  assign in_flag     = in_flag_q;
  assign in_valid    = in_valid_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_flag    = rsp_flag_q;
  assign rsp_tag     = rsp_tag_q;
  assign rsp_timeout = rsp_timeout_q;
  assign err_unexp   = err_unexp_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_kvs_req_client.sv
// -----------------------------------------------------------------------------
// tb_kvs_req_client
// Directed self-checking bench for kvs_req_client. Inputs are driven and
// outputs sampled 1 time unit after each rising edge. Expected tags come from
// the bench's own issue counter and an in-order expected queue.
// -----------------------------------------------------------------------------
module tb_kvs_req_client;
  import kvs_pkg::*;

  localparam int KEY_SIZE = 96;
  localparam int FLAG_W   = 4;
  localparam int MAX_OUT  = 8;
  localparam int TIMEOUT  = 255;
  localparam int TAG_W    = 3;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [KEY_SIZE-1:0] req_key   = '0;
  logic [FLAG_W-1:0]   req_flag  = '0;
  logic                req_valid = 1'b0;
  logic                req_ready;
  logic [TAG_W-1:0]    req_tag;
  logic [KEY_SIZE-1:0] in_key;
  logic [FLAG_W-1:0]   in_flag;
  logic                in_valid;
  logic                out_valid = 1'b0;
  logic [FLAG_W-1:0]   out_flag  = '0;
  logic                rsp_valid;
  logic [FLAG_W-1:0]   rsp_flag;
  logic [TAG_W-1:0]    rsp_tag;
  logic                rsp_timeout;
  logic                err_unexp;
  kvs_state_e          dbg_state;

  kvs_req_client #(
    .KEY_SIZE (KEY_SIZE),
    .FLAG_W   (FLAG_W),
    .MAX_OUT  (MAX_OUT),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_key     (req_key),
    .req_flag    (req_flag),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_tag     (req_tag),
    .in_key      (in_key),
    .in_flag     (in_flag),
    .in_valid    (in_valid),
    .out_valid   (out_valid),
    .out_flag    (out_flag),
    .rsp_valid   (rsp_valid),
    .rsp_flag    (rsp_flag),
    .rsp_tag     (rsp_tag),
    .rsp_timeout (rsp_timeout),
    .err_unexp   (err_unexp),
    .dbg_state   (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int               checks = 0;
  int               errors = 0;
  logic [TAG_W-1:0] exp_q[$];
  logic [TAG_W-1:0] next_tag = '0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_req(input logic [KEY_SIZE-1:0] key, input logic [FLAG_W-1:0] flag);
    req_key   = key;
    req_flag  = flag;
    req_valid = 1'b1;
    check("req_ready", 128'(req_ready), 128'(1));
    check("req_tag", 128'(req_tag), 128'(next_tag));
    step();
    req_valid = 1'b0;
    check("in_valid", 128'(in_valid), 128'(1));
    check("in_key", 128'(in_key), 128'(key));
    check("in_flag", 128'(in_flag), 128'(flag));
    exp_q.push_back(next_tag);
    next_tag = next_tag + TAG_W'(1);
  endtask

  task automatic db_respond(input logic [FLAG_W-1:0] flag);
    logic [TAG_W-1:0] t;
    out_valid = 1'b1;
    out_flag  = flag;
    step();
    out_valid = 1'b0;
    t = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
    check("rsp_valid", 128'(rsp_valid), 128'(1));
    check("rsp_tag", 128'(rsp_tag), 128'(t));
    check("rsp_flag", 128'(rsp_flag), 128'(flag));
    check("rsp_timeout", 128'(rsp_timeout), 128'(0));
  endtask

  task automatic apply_reset();
    #2 rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    exp_q.delete();
    next_tag = '0;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_in_valid"}, 128'(in_valid), 128'(0));
    check({tag, "_in_key"}, 128'(in_key), 128'(0));
    check({tag, "_in_flag"}, 128'(in_flag), 128'(0));
    check({tag, "_rsp_valid"}, 128'(rsp_valid), 128'(0));
    check({tag, "_rsp_flag"}, 128'(rsp_flag), 128'(0));
    check({tag, "_rsp_tag"}, 128'(rsp_tag), 128'(0));
    check({tag, "_rsp_timeout"}, 128'(rsp_timeout), 128'(0));
    check({tag, "_err_unexp"}, 128'(err_unexp), 128'(0));
    check({tag, "_state"}, 128'(dbg_state), 128'(ST_RUN));
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1);
  end

  // ---------------- directed sequence ----------------
  initial begin
    int waited;
    int seen;
    int quiet_cycles;
    int stale;

    // Reset state
    step();
    step();
    check_outputs_zero("reset");
    check("reset_req_ready", 128'(req_ready), 128'(1));
    check("reset_req_tag", 128'(req_tag), 128'(0));
    rst_n = 1'b1;
    step();

    // 1. Single request, DB answers 3 cycles after accept
    send_req(96'h0A000001_0A000002_00500050, FLAG_GET);
    step();
    check("t1_in_pulse", 128'(in_valid), 128'(0));
    step();
    db_respond(FLAG_HIT);
    step();
    check("t1_rsp_pulse", 128'(rsp_valid), 128'(0));

    // 2. Eight back-to-back requests fill the client; tags start from 0
    apply_reset();
    for (int i = 0; i < MAX_OUT; i++) begin
      send_req(96'(32'hC0A80000 + i), FLAG_SET);
    end
    req_valid = 1'b1;
    req_key   = 96'h1234;
    check("t2_full_ready", 128'(req_ready), 128'(0));
    step();
    req_valid = 1'b0;
    check("t2_full_no_issue", 128'(in_valid), 128'(0));
    db_respond(FLAG_HIT);
    check("t2_ready_after_pop", 128'(req_ready), 128'(1));
    check("t2_wrap_tag", 128'(req_tag), 128'(0));
    send_req(96'hDEAD_BEEF, FLAG_GET);
    for (int i = 0; i < 5; i++) db_respond(FLAG_MISS);

    // 3. Simultaneous accept and response with 3 outstanding (tags 6,7,0)
    begin
      logic [TAG_W-1:0] t;
      req_valid = 1'b1;
      req_key   = 96'hABCD;
      req_flag  = FLAG_DEL;
      out_valid = 1'b1;
      out_flag  = FLAG_HIT;
      check("t3_ready", 128'(req_ready), 128'(1));
      check("t3_req_tag", 128'(req_tag), 128'(1));
      step();
      req_valid = 1'b0;
      out_valid = 1'b0;
      check("t3_in_valid", 128'(in_valid), 128'(1));
      t = exp_q.pop_front();
      check("t3_rsp_valid", 128'(rsp_valid), 128'(1));
      check("t3_rsp_tag_oldest", 128'(rsp_tag), 128'(t));
      check("t3_rsp_flag", 128'(rsp_flag), 128'(FLAG_HIT));
      exp_q.push_back(next_tag);
      next_tag = next_tag + TAG_W'(1);
    end
    // Exactly three remain: three answers, then the next one is spurious
    for (int i = 0; i < 3; i++) db_respond(FLAG_HIT);
    check("t3_new_tag_last", 128'(rsp_tag), 128'(1));

    // 5. Spurious response in RUN
    out_valid = 1'b1;
    out_flag  = FLAG_HIT;
    step();
    out_valid = 1'b0;
    check("t5_err_unexp", 128'(err_unexp), 128'(1));
    check("t5_no_rsp", 128'(rsp_valid), 128'(0));
    step();
    check("t5_err_pulse", 128'(err_unexp), 128'(0));

    // 4. Three outstanding, DB silent: flush then quiet period
    for (int i = 0; i < 3; i++) send_req(96'(i + 100), FLAG_GET);
    check("t4_state_run", 128'(dbg_state), 128'(ST_RUN));
    // waited = cycles since the first of the three accepts
    waited = 2;
    seen   = 0;
    while (seen < 3 && waited < 1000) begin
      step();
      waited++;
      if (rsp_valid) begin
        logic [TAG_W-1:0] t;
        t = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
        // age hits TIMEOUT, one cycle to enter FLUSH, one cycle to register
        if (seen == 0) check("t4_flush_latency", 128'(waited), 128'(TIMEOUT + 2));
        check("t4_rsp_timeout", 128'(rsp_timeout), 128'(1));
        check("t4_rsp_flag", 128'(rsp_flag), 128'(0));
        check("t4_rsp_tag", 128'(rsp_tag), 128'(t));
        seen++;
      end
    end
    check("t4_flush_count", 128'(seen), 128'(3));
    check("t4_state_quiet", 128'(dbg_state), 128'(ST_QUIET));
    quiet_cycles = 0;
    while (!req_ready && quiet_cycles < 1000) begin
      quiet_cycles++;
      if (quiet_cycles == 10) begin
        out_valid = 1'b1;
        out_flag  = FLAG_HIT;
      end
      step();
      if (out_valid) begin
        out_valid = 1'b0;
        check("t4_late_no_err", 128'(err_unexp), 128'(0));
        check("t4_late_no_rsp", 128'(rsp_valid), 128'(0));
      end
    end
    check("t4_quiet_cycles", 128'(quiet_cycles), 128'(TIMEOUT));
    check("t4_back_to_run", 128'(dbg_state), 128'(ST_RUN));
    // Tags continue across the flush (next is 5)
    check("t4_tag_continues", 128'(req_tag), 128'(5));

    // 6. Asynchronous reset with 5 outstanding and a response in flight
    for (int i = 0; i < 5; i++) send_req(96'(i + 200), FLAG_SET);
    db_respond(FLAG_MISS);
    #2 rst_n = 1'b0;
    #1;
    check_outputs_zero("t6_async");
    @(posedge clk);
    #1 rst_n = 1'b1;
    exp_q.delete();
    next_tag = '0;
    check("t6_ready", 128'(req_ready), 128'(1));
    send_req(96'h0A000001_0A000002_00500051, FLAG_GET);
    stale = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (rsp_valid || err_unexp) stale++;
    end
    check("t6_no_stale", 128'(stale), 128'(0));
    db_respond(FLAG_HIT);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
